// File: rtl/dcache_pkg.sv
// Shared types and address helpers for the direct-mapped write-back data cache.
// Holds the FSM state encoding, default geometry and the tag/index/offset extractors.
package dcache_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        ALLOCATE  = 2'd2
    } state_t;

    localparam int DEF_LINES      = 8;
    localparam int DEF_WORDS_LINE = 4;
    localparam int DEF_ADDR_W     = 30;
    localparam int WORD_W         = 64;

    function automatic logic [63:0] addr_field(input logic [63:0] addr, input int lsb, input int width);
        return (addr >> lsb) & ((64'd1 << width) - 64'd1);
    endfunction

    function automatic logic [63:0] addr_offset(input logic [63:0] addr, input int ofs_w);
        return addr_field(addr, 0, ofs_w);
    endfunction

    function automatic logic [63:0] addr_index(input logic [63:0] addr, input int ofs_w, input int idx_w);
        return addr_field(addr, ofs_w, idx_w);
    endfunction

    function automatic logic [63:0] addr_tag(input logic [63:0] addr, input int ofs_w, input int idx_w,
                                             input int tag_w);
        return addr_field(addr, ofs_w + idx_w, tag_w);
    endfunction

endpackage

// File: rtl/dcache_dm_wb_if.sv
// Core-side and memory-side signals of the data cache in one bundle.
// The slave modport is the cache; the master modport is the core plus line memory around it.
interface dcache_dm_wb_if
    import dcache_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int WORDS_LINE = DEF_WORDS_LINE
);
    localparam int OFS_W = $clog2(WORDS_LINE);

    logic                         proc_read;
    logic                         proc_write;
    logic [ADDR_W-1:0]            proc_addr;
    logic [WORD_W-1:0]            proc_wdata;
    logic [WORD_W-1:0]            proc_rdata;
    logic                         proc_stall;
    logic                         mem_read;
    logic                         mem_write;
    logic [ADDR_W-OFS_W-1:0]      mem_addr;
    logic [WORD_W*WORDS_LINE-1:0] mem_wdata;
    logic [WORD_W*WORDS_LINE-1:0] mem_rdata;
    logic                         mem_ready;

    modport slave (
        input  proc_read, proc_write, proc_addr, proc_wdata, mem_rdata, mem_ready,
        output proc_rdata, proc_stall, mem_read, mem_write, mem_addr, mem_wdata
    );

    modport master (
        output proc_read, proc_write, proc_addr, proc_wdata, mem_rdata, mem_ready,
        input  proc_rdata, proc_stall, mem_read, mem_write, mem_addr, mem_wdata
    );

endinterface

// File: rtl/dcache_line_array.sv
// Valid/dirty/tag/data storage for the cache: one write port (word store or line fill)
// and a combinational read of the addressed line.
module dcache_line_array
    import dcache_pkg::*;
#(
    parameter int LINES      = DEF_LINES,
    parameter int WORDS_LINE = DEF_WORDS_LINE,
    parameter int TAG_W      = 25,
    localparam int INDEX_W   = $clog2(LINES),
    localparam int OFS_W     = $clog2(WORDS_LINE),
    localparam int LINE_W    = WORD_W * WORDS_LINE
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [INDEX_W-1:0] idx,
    input  logic               word_we,
    input  logic [OFS_W-1:0]   ofs,
    input  logic [WORD_W-1:0]  word_data,
    input  logic               fill_we,
    input  logic [TAG_W-1:0]   fill_tag,
    input  logic [LINE_W-1:0]  fill_data,
    output logic               rd_valid,
    output logic               rd_dirty,
    output logic [TAG_W-1:0]   rd_tag,
    output logic [LINE_W-1:0]  rd_line
);

    logic [LINES-1:0]  valid_q;
    logic [LINES-1:0]  dirty_q;
    logic [TAG_W-1:0]  tag_q  [LINES];
    logic [LINE_W-1:0] data_q [LINES];

    // NOTE: sequential state is written with <= so every flop samples pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (fill_we) begin
            valid_q[idx] <= 1'b1;
            dirty_q[idx] <= 1'b0;
        end else if (word_we) begin
            dirty_q[idx] <= 1'b1;
        end
    end

    // NOTE: tag and data arrays are deliberately not reset; valid gates their use, so they can map to plain RAM.
    always_ff @(posedge clk) begin
        if (fill_we) begin
            tag_q[idx]  <= fill_tag;
            data_q[idx] <= fill_data;
        end else if (word_we) begin
            data_q[idx][int'(ofs)*WORD_W +: WORD_W] <= word_data;
        end
    end

    assign rd_valid = valid_q[idx];
    assign rd_dirty = dirty_q[idx];
    assign rd_tag   = tag_q[idx];
    assign rd_line  = data_q[idx];

endmodule

// File: rtl/dcache_dm_wb.sv
// Direct-mapped, write-back, write-allocate data cache: same-cycle hits, FSM-driven victim write-back and refill.
// Define DCACHE_STAT_EN to add the access_cnt/miss_cnt statistics outputs.
module dcache_dm_wb
    import dcache_pkg::*;
#(
    parameter int LINES      = DEF_LINES,
    parameter int WORDS_LINE = DEF_WORDS_LINE,
    parameter int ADDR_W     = DEF_ADDR_W
) (
    input  logic               clk,
    input  logic               rst,
    dcache_dm_wb_if.slave      bus
`ifdef DCACHE_STAT_EN
    ,
    output logic [31:0]        access_cnt,
    output logic [31:0]        miss_cnt
`endif
);

    localparam int INDEX_W = $clog2(LINES);
    localparam int OFS_W   = $clog2(WORDS_LINE);
    localparam int TAG_W   = ADDR_W - INDEX_W - OFS_W;
    localparam int LINE_W  = WORD_W * WORDS_LINE;
    localparam int LADDR_W = ADDR_W - OFS_W;

    logic [63:0]        addr_ext;
    logic [TAG_W-1:0]   req_tag;
    logic [INDEX_W-1:0] req_idx;
    logic [OFS_W-1:0]   req_ofs;

    assign addr_ext = 64'(bus.proc_addr);
    assign req_ofs  = OFS_W'(addr_offset(addr_ext, OFS_W));
    assign req_idx  = INDEX_W'(addr_index(addr_ext, OFS_W, INDEX_W));
    assign req_tag  = TAG_W'(addr_tag(addr_ext, OFS_W, INDEX_W, TAG_W));

    state_t              state;
    logic                mem_read_q;
    logic                mem_write_q;
    logic [LADDR_W-1:0]  mem_addr_q;

    logic                rd_valid;
    logic                rd_dirty;
    logic [TAG_W-1:0]    rd_tag;
    logic [LINE_W-1:0]   rd_line;

    logic                is_read;
    logic                is_write;
    logic                req;
    logic                in_idle;
    logic                hit;
    logic                miss;
    logic                stall;
    logic                word_we;
    logic                fill_we;
    logic [WORD_W-1:0]   rdata;

    dcache_line_array #(
        .LINES      (LINES),
        .WORDS_LINE (WORDS_LINE),
        .TAG_W      (TAG_W)
    ) u_lines (
        .clk       (clk),
        .rst       (rst),
        .idx       (req_idx),
        .word_we   (word_we),
        .ofs       (req_ofs),
        .word_data (bus.proc_wdata),
        .fill_we   (fill_we),
        .fill_tag  (req_tag),
        .fill_data (bus.mem_rdata),
        .rd_valid  (rd_valid),
        .rd_dirty  (rd_dirty),
        .rd_tag    (rd_tag),
        .rd_line   (rd_line)
    );

    always_comb begin
        // A store wins over a load when the core raises both.
        is_write = bus.proc_write;
        is_read  = bus.proc_read && !bus.proc_write;
        req      = is_read || is_write;
        in_idle  = (state == IDLE);
        hit      = rd_valid && (rd_tag == req_tag);
        miss     = in_idle && req && !hit;
        stall    = !in_idle || miss;
        word_we  = in_idle && is_write && hit;
        fill_we  = (state == ALLOCATE) && bus.mem_ready;
        // NOTE: give every always_comb output a default before any conditional so no path infers a latch.
        rdata    = '0;
        if (in_idle && is_read && hit) begin
            rdata = rd_line[int'(req_ofs)*WORD_W +: WORD_W];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (miss) begin
                        if (rd_valid && rd_dirty) begin
                            state       <= WRITEBACK;
                            mem_write_q <= 1'b1;
                            mem_addr_q  <= {rd_tag, req_idx};
                        end else begin
                            state      <= ALLOCATE;
                            mem_read_q <= 1'b1;
                            mem_addr_q <= {req_tag, req_idx};
                        end
                    end
                end
                WRITEBACK: begin
                    // Victim data comes straight from the array, which cannot change while the core is stalled.
                    if (bus.mem_ready) begin
                        state       <= ALLOCATE;
                        mem_write_q <= 1'b0;
                        mem_read_q  <= 1'b1;
                        mem_addr_q  <= {req_tag, req_idx};
                    end
                end
                ALLOCATE: begin
                    if (bus.mem_ready) begin
                        state      <= IDLE;
                        mem_read_q <= 1'b0;
                    end
                end
                default: begin
                    state       <= IDLE;
                    mem_read_q  <= 1'b0;
                    mem_write_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.proc_rdata = rdata;
    assign bus.proc_stall = stall;
    assign bus.mem_read   = mem_read_q;
    assign bus.mem_write  = mem_write_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_wdata  = rd_line;

`ifdef DCACHE_STAT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            access_cnt <= '0;
            miss_cnt   <= '0;
        end else begin
            if (req && !stall) access_cnt <= access_cnt + 32'd1;
            if (miss)          miss_cnt   <= miss_cnt + 32'd1;
        end
    end
`endif

endmodule
